// File: rtl/sin_cos_osc_if.sv
// Bus bundle for the quadrature oscillator: control inputs plus sample/period outputs.
// No latency of its own; carries the registered outputs of sin_cos_osc unchanged.
// No backpressure: samples are announced by sample_vld and must be taken that cycle.
interface sin_cos_osc_if #(
  parameter int WIDTH   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4,
  parameter int PCNT_W  = 16
);
  logic                      load;
  logic signed [WIDTH-1:0]   amp;
  logic        [SHIFT_W-1:0] shift;
  logic                      en;
  logic        [OUT_W-1:0]   sin_out;
  logic        [OUT_W-1:0]   cos_out;
  logic                      sample_vld;
  logic                      zc;
  logic        [PCNT_W-1:0]  period;
  logic                      period_vld;
  logic                      running;
`ifdef SINWAVE_SAT_EN
  logic                      sat_flag;
`endif

  modport master (
    output load, amp, shift, en,
    input  sin_out, cos_out, sample_vld, zc, period, period_vld, running
`ifdef SINWAVE_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  load, amp, shift, en,
    output sin_out, cos_out, sample_vld, zc, period, period_vld, running
`ifdef SINWAVE_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/sin_cos_osc.sv
// Quadrature oscillator (Minsky recursion) with offset-binary outputs, zero-crossing flag and period counter.
// Latency: a step accepted at edge N is visible on all outputs in cycle N+1 (sample_vld high for that cycle).
// No backpressure: en gaps freeze the state; optional macro SINWAVE_SAT_EN selects saturating sums and adds sat_flag.
module sin_cos_osc #(
  parameter int WIDTH   = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4,
  parameter int PCNT_W  = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  sin_cos_osc_if.slave bus
);

  localparam logic [OUT_W-1:0]        MID  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [WIDTH-1:0]   r_s;
  logic signed [WIDTH-1:0]   r_c;
  logic        [SHIFT_W-1:0] r_k;
  logic        [PCNT_W-1:0]  r_cnt;
  logic        [PCNT_W-1:0]  r_period;
  logic        [OUT_W-1:0]   r_sin;
  logic        [OUT_W-1:0]   r_cos;
  logic                      r_vld;
  logic                      r_zc;
  logic                      r_sat;

  logic                      w_step;
  logic                      w_cross;
  logic                      w_ovf;
  logic signed [WIDTH-1:0]   w_c_sh;
  logic signed [WIDTH-1:0]   w_s_sh;
  logic signed [WIDTH-1:0]   w_s_new;
  logic signed [WIDTH-1:0]   w_c_new;
  logic        [PCNT_W-1:0]  w_cnt_inc;
`ifdef SINWAVE_SAT_EN
  logic signed [WIDTH:0]     w_s_wide;
  logic signed [WIDTH:0]     w_c_wide;
  logic                      w_s_ovf;
  logic                      w_c_ovf;
`endif

  // State register: reset parks in IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: load starts (or restarts) the oscillator from either state
  always_comb begin
    w_state_nxt = r_state;
    if (bus.load) w_state_nxt = ST_RUN;
  end

  // Step qualifier: load wins over en, and en is ignored outside RUN
  assign w_step = (r_state == ST_RUN) && bus.en && !bus.load;

  // Coupled recursion; the cosine update uses the freshly computed sine to keep the orbit closed
  always_comb begin
    w_c_sh  = r_c >>> r_k;
`ifdef SINWAVE_SAT_EN
    w_s_wide = {r_s[WIDTH-1], r_s} + {w_c_sh[WIDTH-1], w_c_sh};
    w_s_ovf  = w_s_wide[WIDTH] ^ w_s_wide[WIDTH-1];
    w_s_new  = w_s_ovf ? (w_s_wide[WIDTH] ? SMIN : SMAX) : w_s_wide[WIDTH-1:0];
    w_s_sh   = w_s_new >>> r_k;
    w_c_wide = {r_c[WIDTH-1], r_c} - {w_s_sh[WIDTH-1], w_s_sh};
    w_c_ovf  = w_c_wide[WIDTH] ^ w_c_wide[WIDTH-1];
    w_c_new  = w_c_ovf ? (w_c_wide[WIDTH] ? SMIN : SMAX) : w_c_wide[WIDTH-1:0];
    w_ovf    = w_s_ovf | w_c_ovf;
`else
    w_s_new = r_s + w_c_sh;
    w_s_sh  = w_s_new >>> r_k;
    w_c_new = r_c - w_s_sh;
    w_ovf   = 1'b0;
`endif
  end

  // Positive-going crossing: negative before the step, non-negative after it
  assign w_cross   = r_s[WIDTH-1] & ~w_s_new[WIDTH-1];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // Datapath, output and period registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s      <= '0;
      r_c      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_period <= '0;
      r_sin    <= MID;
      r_cos    <= MID;
      r_vld    <= 1'b0;
      r_zc     <= 1'b0;
      r_sat    <= 1'b0;
    end else if (bus.load) begin
      // Outputs and period are left alone; they change at the first step
      r_s   <= '0;
      r_c   <= bus.amp;
      r_k   <= bus.shift;
      r_cnt <= '0;
      r_vld <= 1'b0;
      r_zc  <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_vld <= w_step;
      r_zc  <= w_step & w_cross;
      if (w_step) begin
        r_s   <= w_s_new;
        r_c   <= w_c_new;
        r_sin <= w_s_new[WIDTH-1 -: OUT_W] ^ MID;
        r_cos <= w_c_new[WIDTH-1 -: OUT_W] ^ MID;
        r_sat <= r_sat | w_ovf;
        if (w_cross) begin
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= w_cnt_inc;
        end
      end
    end
  end

  assign bus.sin_out    = r_sin;
  assign bus.cos_out    = r_cos;
  assign bus.sample_vld = r_vld;
  assign bus.zc         = r_zc;
  assign bus.period_vld = r_zc;
  assign bus.period     = r_period;
  assign bus.running    = (r_state == ST_RUN);
`ifdef SINWAVE_SAT_EN
  assign bus.sat_flag   = r_sat;
`endif

endmodule

// File: tb/tb_sin_cos_osc.sv
// Directed bench for sin_cos_osc: vector table of load/step cases plus reset, period, precedence and gap sequences.
// Inputs change on the falling edge; outputs are compared on the falling edge after the active edge.
// Expected values are hand-computed constants and ranges.
module tb_sin_cos_osc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sin_cos_osc_if #(.WIDTH(16), .OUT_W(8), .SHIFT_W(4), .PCNT_W(16)) bus ();

  sin_cos_osc #(.WIDTH(16), .OUT_W(8), .SHIFT_W(4), .PCNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic signed [15:0] amp;
    logic [3:0]         shift;
    int                 steps;
    logic [7:0]         exp_sin;
    logic [7:0]         exp_cos;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected range %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic do_load(input logic signed [15:0] a, input logic [3:0] k);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.amp   = a;
    bus.shift = k;
    bus.en    = 1'b0;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic run(input int n);
    bus.en = 1'b1;
    repeat (n) @(negedge clk);
    bus.en = 1'b0;
  endtask

  initial begin
    int nzc, bad, jumps, smax, smin, prev_cos, have_prev, d;

    // amp, shift, steps, expected sin_out, expected cos_out
    vecs[0] = '{16'sd30000,  4'd6, 1, 8'h81, 8'hF5};
    vecs[1] = '{16'sd1000,   4'd0, 1, 8'h83, 8'h80};
    vecs[2] = '{16'sd1000,   4'd0, 2, 8'h83, 8'h7C};
    vecs[3] = '{16'sd1000,   4'd0, 4, 8'h7C, 8'h80};
`ifdef SINWAVE_SAT_EN
    vecs[4] = '{16'sh8000,   4'd0, 2, 8'h00, 8'hFF};
`else
    vecs[4] = '{16'sh8000,   4'd0, 2, 8'h00, 8'h00};
`endif
    vecs[5] = '{16'sd16384,  4'd1, 1, 8'hA0, 8'hB0};
    vecs[6] = '{16'sd16384,  4'd1, 2, 8'hB8, 8'h94};
    vecs[7] = '{-16'sd30000, 4'd6, 1, 8'h7E, 8'h0A};

    bus.load  = 1'b0;
    bus.amp   = '0;
    bus.shift = '0;
    bus.en    = 1'b0;

    // Reset values, then en without load must be ignored
    repeat (3) @(negedge clk);
    chk("rst_sin", bus.sin_out, 8'h80);
    chk("rst_cos", bus.cos_out, 8'h80);
    chk("rst_vld", bus.sample_vld, 0);
    chk("rst_zc", bus.zc, 0);
    chk("rst_pvld", bus.period_vld, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_running", bus.running, 0);
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_sin", bus.sin_out, 8'h80);
      chk("idle_cos", bus.cos_out, 8'h80);
      chk("idle_vld", bus.sample_vld, 0);
    end
    bus.en = 1'b0;

    // Vector table: load, n steps, compare the last sample and the one-cycle valid
    for (int v = 0; v < 8; v++) begin
      do_load(vecs[v].amp, vecs[v].shift);
      chk("load_running", bus.running, 1);
      chk("load_vld", bus.sample_vld, 0);
`ifdef SINWAVE_SAT_EN
      chk("load_sat_clr", bus.sat_flag, 0);
`endif
      run(vecs[v].steps);
      chk($sformatf("vec%0d_sin", v), bus.sin_out, vecs[v].exp_sin);
      chk($sformatf("vec%0d_cos", v), bus.cos_out, vecs[v].exp_cos);
      chk($sformatf("vec%0d_vld", v), bus.sample_vld, 1);
`ifdef SINWAVE_SAT_EN
      chk($sformatf("vec%0d_sat", v), bus.sat_flag, (v == 4) ? 1 : 0);
`endif
      @(negedge clk);
      chk($sformatf("vec%0d_vld_drop", v), bus.sample_vld, 0);
    end

    // Long run at k=6: period ~402 steps, bounded amplitude
    do_load(16'sd30000, 4'd6);
    nzc = 0; bad = 0; jumps = 0; smax = 0; smin = 255; have_prev = 0; prev_cos = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.sample_vld !== 1'b1) bad++;
      if (bus.period_vld !== bus.zc) bad++;
      if (bus.sample_vld) begin
        if (have_prev != 0) begin
          d = int'(bus.cos_out) - prev_cos;
          if (d > 64 || d < -64) jumps++;
        end
        prev_cos  = bus.cos_out;
        have_prev = 1;
        if (bus.sin_out > smax) smax = bus.sin_out;
        if (bus.sin_out < smin) smin = bus.sin_out;
      end
      if (bus.zc) begin
        nzc++;
        chk_rng("period_k6", bus.period, 401, 403);
      end
    end
    bus.en = 1'b0;
    chk_rng("zc_count_k6", nzc, 4, 5);
    chk_rng("sin_peak", smax, 8'hEE, 8'hF6);
    chk_rng("sin_trough", smin, 8'h09, 8'h12);
    chk("cos_wrap_jumps", jumps, 0);
    chk("vld_zc_consistency", bad, 0);

    // k=0: every period is exactly 6 steps
    do_load(16'sd1000, 4'd0);
    nzc = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.zc) begin
        nzc++;
        chk("period_k0", bus.period, 6);
      end
    end
    bus.en = 1'b0;
    chk("zc_count_k0", nzc, 6);

    // Period survives a load
    do_load(16'sd1000, 4'd0);
    chk("period_hold_after_load", bus.period, 6);
    chk("zc_clear_after_load", bus.zc, 0);

    // load with en in the same cycle: no step, so one further step gives the 1-step result
    @(negedge clk);
    bus.load = 1'b1; bus.amp = 16'sd1000; bus.shift = 4'd0; bus.en = 1'b1;
    @(negedge clk);
    bus.load = 1'b0; bus.en = 1'b0;
    chk("load_en_no_vld", bus.sample_vld, 0);
    run(1);
    chk("load_en_sin", bus.sin_out, 8'h83);
    chk("load_en_cos", bus.cos_out, 8'h80);

    // en gaps freeze state and drop sample_vld
    do_load(16'sd1000, 4'd0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("gap_vld1", bus.sample_vld, 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("gap_vld0", bus.sample_vld, 0);
    chk("gap_sin_frozen", bus.sin_out, 8'h83);
    chk("gap_cos_frozen", bus.cos_out, 8'h80);
    bus.en = 1'b1;
    @(negedge clk);
    chk("gap_vld2", bus.sample_vld, 1);
    chk("gap_cos_step2", bus.cos_out, 8'h7C);

    // rst mid-run with en still high
    run(5);
    bus.en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sin", bus.sin_out, 8'h80);
    chk("midrst_cos", bus.cos_out, 8'h80);
    chk("midrst_vld", bus.sample_vld, 0);
    chk("midrst_zc", bus.zc, 0);
    chk("midrst_period", bus.period, 0);
    chk("midrst_running", bus.running, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_vld", bus.sample_vld, 0);
      chk("postrst_sin", bus.sin_out, 8'h80);
    end
    bus.en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
